// File: rtl/pad_mux_ctrl.sv
// Per-pad ownership controller for shared I/O pads: sequences GPIO <-> alternate-function
// handover through a tri-stated dead time so two drivers never fight on a pad.
module pad_mux_ctrl #(
    parameter int unsigned NPADS    = 5,
    parameter int unsigned DEAD_CYC = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mux_lock,
    input  logic [NPADS-1:0] alt_en,
    input  logic [NPADS-1:0] alt_o,
    input  logic [NPADS-1:0] alt_oe,
    input  logic [NPADS-1:0] gpio_o,
    input  logic [NPADS-1:0] gpio_oe,
    input  logic [NPADS-1:0] pad_in,
    output logic [NPADS-1:0] pad_out,
    output logic [NPADS-1:0] pad_oeb,
    output logic [NPADS-1:0] gpio_i,
    output logic [NPADS-1:0] alt_i,
    output logic [NPADS-1:0] alt_own,
    output logic [NPADS-1:0] busy
);

    localparam int unsigned CW = $clog2(DEAD_CYC + 1);

    typedef enum logic [1:0] {
        S_GPIO = 2'd0,
        S_DEAD = 2'd1,
        S_ALT  = 2'd2
    } state_e;

    state_e          state_q [NPADS];
    state_e          state_d [NPADS];
    logic [CW-1:0]   cnt_q   [NPADS];
    logic [CW-1:0]   cnt_d   [NPADS];

    logic [NPADS-1:0] pad_out_d;
    logic [NPADS-1:0] pad_oeb_d;
    logic [NPADS-1:0] alt_own_d;
    logic [NPADS-1:0] busy_d;

    // State, dead-time counters and registered pad outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NPADS; i++) begin
                state_q[i] <= S_GPIO;
                cnt_q[i]   <= '0;
            end
            pad_out <= '0;
            pad_oeb <= '1;
            alt_own <= '0;
            busy    <= '0;
        end else begin
            for (int i = 0; i < NPADS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pad_out <= pad_out_d;
            pad_oeb <= pad_oeb_d;
            alt_own <= alt_own_d;
            busy    <= busy_d;
        end
    end

    // Next state: the lock only blocks leaving a stable owner, never an active dead time
    always_comb begin
        for (int i = 0; i < NPADS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                S_GPIO: begin
                    if (alt_en[i] && !mux_lock) begin
                        state_d[i] = S_DEAD;
                        cnt_d[i]   = CW'(DEAD_CYC - 1);
                    end
                end
                S_ALT: begin
                    if (!alt_en[i] && !mux_lock) begin
                        state_d[i] = S_DEAD;
                        cnt_d[i]   = CW'(DEAD_CYC - 1);
                    end
                end
                S_DEAD: begin
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - CW'(1);
                    end else begin
                        state_d[i] = alt_en[i] ? S_ALT : S_GPIO;
                    end
                end
                default: begin
                    state_d[i] = S_GPIO;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Pad drive follows the state being entered, with data sampled on the same edge
    always_comb begin
        pad_out_d = '0;
        pad_oeb_d = '1;
        alt_own_d = '0;
        busy_d    = '0;
        for (int i = 0; i < NPADS; i++) begin
            case (state_d[i])
                S_GPIO: begin
                    pad_out_d[i] = gpio_o[i];
                    pad_oeb_d[i] = ~gpio_oe[i];
                end
                S_ALT: begin
                    pad_out_d[i] = alt_o[i];
                    pad_oeb_d[i] = ~alt_oe[i];
                    alt_own_d[i] = 1'b1;
                end
                S_DEAD: begin
                    busy_d[i] = 1'b1;
                end
                default: begin
                    busy_d[i] = 1'b0;
                end
            endcase
        end
    end

    assign gpio_i = pad_in;
    assign alt_i  = pad_in;

endmodule

// File: tb/tb_pad_mux_ctrl.sv
// Self-checking bench for pad_mux_ctrl: per-pad ownership model based on edge counts,
// compared every cycle, plus directed literal checks of handover timing.
module tb_pad_mux_ctrl;

    localparam int unsigned NPADS    = 5;
    localparam int unsigned DEAD_CYC = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             mux_lock;
    logic [NPADS-1:0] alt_en, alt_o, alt_oe, gpio_o, gpio_oe, pad_in;
    logic [NPADS-1:0] pad_out, pad_oeb, gpio_i, alt_i, alt_own, busy;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    pad_mux_ctrl #(.NPADS(NPADS), .DEAD_CYC(DEAD_CYC)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .mux_lock(mux_lock),
        .alt_en  (alt_en),
        .alt_o   (alt_o),
        .alt_oe  (alt_oe),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .pad_in  (pad_in),
        .pad_out (pad_out),
        .pad_oeb (pad_oeb),
        .gpio_i  (gpio_i),
        .alt_i   (alt_i),
        .alt_own (alt_own),
        .busy    (busy)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [NPADS-1:0] act, input logic [NPADS-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Model: each pad has an owner and an optional dead window that began on edge m_start
    int               m_cyc;
    bit               m_dead  [NPADS];
    bit               m_own   [NPADS];
    int               m_start [NPADS];
    logic [NPADS-1:0] s_alt_o, s_alt_oe, s_gpio_o, s_gpio_oe;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_cyc <= 0;
            for (int i = 0; i < NPADS; i++) begin
                m_dead[i]  <= 1'b0;
                m_own[i]   <= 1'b0;
                m_start[i] <= 0;
            end
            s_alt_o <= '0; s_alt_oe <= '0; s_gpio_o <= '0; s_gpio_oe <= '0;
        end else begin
            m_cyc <= m_cyc + 1;
            for (int i = 0; i < NPADS; i++) begin
                if (m_dead[i]) begin
                    if (m_cyc - m_start[i] == int'(DEAD_CYC)) begin
                        m_dead[i] <= 1'b0;
                        m_own[i]  <= alt_en[i];
                    end
                end else if (!mux_lock && (alt_en[i] != m_own[i])) begin
                    m_dead[i]  <= 1'b1;
                    m_start[i] <= m_cyc;
                end
            end
            s_alt_o <= alt_o; s_alt_oe <= alt_oe; s_gpio_o <= gpio_o; s_gpio_oe <= gpio_oe;
        end
    end

    logic [NPADS-1:0] e_out, e_oeb, e_own, e_busy;

    always @(negedge clk_i) begin
        if (chk_en) begin
            e_out = '0; e_oeb = '1; e_own = '0; e_busy = '0;
            for (int i = 0; i < NPADS; i++) begin
                if (m_dead[i]) begin
                    e_busy[i] = 1'b1;
                end else if (m_own[i]) begin
                    e_own[i] = 1'b1;
                    e_out[i] = s_alt_o[i];
                    e_oeb[i] = ~s_alt_oe[i];
                end else begin
                    e_out[i] = s_gpio_o[i];
                    e_oeb[i] = ~s_gpio_oe[i];
                end
            end
            chk("model pad_out", pad_out, e_out);
            chk("model pad_oeb", pad_oeb, e_oeb);
            chk("model alt_own", alt_own, e_own);
            chk("model busy",    busy,    e_busy);
            chk("gpio_i",        gpio_i,  pad_in);
            chk("alt_i",         alt_i,   pad_in);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        pad_in = NPADS'($urandom);
    endtask

    initial begin
        rst_ni = 1'b1; mux_lock = 1'b0;
        alt_en = NPADS'($urandom); alt_o = NPADS'($urandom); alt_oe = NPADS'($urandom);
        gpio_o = NPADS'($urandom); gpio_oe = NPADS'($urandom); pad_in = NPADS'($urandom);
        mux_lock = 1'($urandom);

        // 1. Asynchronous reset with random inputs
        #2 rst_ni = 1'b0;
        #1;
        chk("rst pad_oeb", pad_oeb, 5'b11111);
        chk("rst pad_out", pad_out, 5'b00000);
        chk("rst alt_own", alt_own, 5'b00000);
        chk("rst busy",    busy,    5'b00000);
        chk_en = 1'b1;
        repeat (3) begin
            tick();
            alt_en = NPADS'($urandom); alt_o = NPADS'($urandom); gpio_oe = NPADS'($urandom);
        end
        chk("rst hold pad_oeb", pad_oeb, 5'b11111);
        alt_en = '0; alt_o = '0; alt_oe = '0; gpio_o = '0; gpio_oe = '0; mux_lock = 1'b0;
        rst_ni = 1'b1;
        tick();
        gpio_oe[0] = 1'b1; gpio_o[0] = 1'b1;
        tick();
        chk("gpio0 oeb", pad_oeb, 5'b11110);
        chk("gpio0 out", pad_out, 5'b00001);

        // 2. Handover of pad 2 to the alternate function
        alt_en[2] = 1'b1; alt_oe[2] = 1'b1; alt_o[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ho2 busy", busy & 5'b00100, 5'b00100);
            chk("ho2 oeb",  pad_oeb & 5'b00100, 5'b00100);
        end
        tick();
        chk("ho2 alt_own", alt_own, 5'b00100);
        chk("ho2 busy end", busy, 5'b00000);
        chk("ho2 out", pad_out & 5'b00100, 5'b00100);
        chk("ho2 oeb end", pad_oeb & 5'b00100, 5'b00000);

        // 3. Release of pad 2 back to GPIO
        gpio_o[2] = 1'b1; gpio_oe[2] = 1'b1; alt_en[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rel2 busy", busy & 5'b00100, 5'b00100);
        end
        tick();
        chk("rel2 alt_own", alt_own, 5'b00000);
        chk("rel2 busy end", busy, 5'b00000);
        chk("rel2 out", pad_out & 5'b00100, 5'b00100);

        // 4. One-cycle pulse on pad 1, repulsed mid-dead: no extension
        alt_en[1] = 1'b1; tick();
        chk("gl1 busy k", busy, 5'b00010);
        alt_en[1] = 1'b0; tick();
        alt_en[1] = 1'b1; tick();
        alt_en[1] = 1'b0; tick();
        chk("gl1 busy k+3", busy, 5'b00010);
        tick();
        chk("gl1 busy k+4", busy, 5'b00000);
        chk("gl1 alt_own", alt_own, 5'b00000);

        // 5. Lock blocks entry to dead time but not its completion
        mux_lock = 1'b1; alt_en[3] = 1'b1; alt_o[3] = 1'b1; alt_oe[3] = 1'b1;
        repeat (20) tick();
        chk("lock busy", busy, 5'b00000);
        chk("lock own", alt_own, 5'b00000);
        mux_lock = 1'b0; tick();
        chk("unlock busy", busy, 5'b01000);
        mux_lock = 1'b1;
        repeat (3) tick();
        chk("lock dead busy", busy, 5'b01000);
        tick();
        chk("lock dead own", alt_own, 5'b01000);
        chk("lock dead out", pad_out & 5'b01000, 5'b01000);
        mux_lock = 1'b0;

        // 6. All pads in parallel, then reset in the 2nd dead cycle
        alt_en = '0;
        repeat (5) tick();
        chk("par idle own", alt_own, 5'b00000);
        alt_en = 5'b11111; alt_oe = 5'b10101; alt_o = 5'b11011;
        repeat (4) tick();
        chk("par busy", busy, 5'b11111);
        tick();
        chk("par own", alt_own, 5'b11111);
        chk("par oeb", pad_oeb, 5'b01010);
        chk("par out", pad_out, 5'b11011);
        alt_en = '0;
        tick();
        tick();
        chk("par dead2 busy", busy, 5'b11111);
        rst_ni = 1'b0;
        #1;
        chk("midrst oeb", pad_oeb, 5'b11111);
        chk("midrst out", pad_out, 5'b00000);
        chk("midrst busy", busy, 5'b00000);
        chk("midrst own", alt_own, 5'b00000);
        repeat (2) tick();
        rst_ni = 1'b1;
        repeat (6) tick();
        chk("post rst own", alt_own, 5'b00000);
        chk("post rst busy", busy, 5'b00000);

        @(negedge clk_i);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pad_mux_ctrl.md
Name: pad_mux_ctrl

Overview:
Per-pad ownership controller for the SoC's shared I/O pads. Today GPIO pins double as SPI slave-selects and PWM outputs through a purely combinational mux. This block replaces that mux with a sequenced handover. On every change of owner between GPIO and the alternate function, the pad is tri-stated for a programmable dead time, so two drivers never fight and the pad never glitches. It sits between azadi_soc_top's peripheral pins and the io_out/io_oeb pad bus of the caravel wrapper.

Parameters:
NPADS, 5, number of shared pads handled (independent channel per pad)
DEAD_CYC, 4, dead-time length in clk_i cycles; legal range 1..255
CW, $clog2(DEAD_CYC+1), dead-time counter width (derived, not overridable)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  reset; asynchronous, active-low
mux_lock  input  1  1 = freeze ownership; no new handovers start
alt_en  input  NPADS  alternate function requests the pad (e.g. sd_oe, pwm1_oe)
alt_o  input  NPADS  alternate-function output data
alt_oe  input  NPADS  alternate-function output enable, active high
gpio_o  input  NPADS  GPIO output data
gpio_oe  input  NPADS  GPIO output enable, active high
pad_in  input  NPADS  pad input value (io_in slice)
pad_out  output  NPADS  registered pad output data
pad_oeb  output  NPADS  registered pad output enable, active low
gpio_i  output  NPADS  pad_in to GPIO, combinational passthrough
alt_i  output  NPADS  pad_in to alternate function, combinational passthrough
alt_own  output  NPADS  registered; 1 = pad currently owned by alternate function
busy  output  NPADS  registered; 1 = pad is in dead time

Behaviour:
- Reset (rst_ni low, async): every channel enters S_GPIO with the counter at 0. pad_out=0, pad_oeb=all 1 (tri-state), alt_own=0, busy=0. Outputs take these values immediately, not on the next clock edge.
- Each pad has an independent 3-state FSM: S_GPIO, S_DEAD, S_ALT. Pads never interact.
- Outputs are registered. The value after edge k reflects the state entered at edge k and the data/oe inputs sampled at edge k. Latency from input to pad is 1 cycle.
- S_GPIO: pad_out=gpio_o, pad_oeb=~gpio_oe. If alt_en=1 and mux_lock=0, go to S_DEAD and load the counter with DEAD_CYC-1.
- S_ALT: pad_out=alt_o, pad_oeb=~alt_oe. If alt_en=0 and mux_lock=0, go to S_DEAD and load the counter with DEAD_CYC-1.
- S_DEAD: pad_out=0, pad_oeb=1, busy=1.
  - While the counter is nonzero, decrement it.
  - When the counter is 0, leave S_DEAD: go to S_ALT if alt_en=1 at that edge, else S_GPIO.
  - The pad is therefore tri-stated for exactly DEAD_CYC cycles.
- alt_en toggling during S_DEAD does not restart or extend the dead time. Only its value at expiry matters. Expiry may return the pad to its previous owner.
- mux_lock=1 only blocks the exits from S_GPIO and S_ALT. An S_DEAD already in progress always completes. mux_lock does not gate output data or oe.
- alt_own=1 exactly when the state is S_ALT. busy=1 exactly when the state is S_DEAD. Both are registered together with pad_out.
- gpio_i and alt_i always equal pad_in, whatever the owner. Input gating is the consumer's responsibility.
- Simultaneous requests across pads are handled fully in parallel, with no arbitration between pads.
- Reset asserted mid-S_DEAD or mid-S_ALT: the channel immediately returns to reset values. After release, the first transition needs a fresh alt_en sample.
- The counter never wraps. It is only loaded on entry to S_DEAD and decremented while nonzero.

Test Plan:
1. Reset: hold rst_ni=0 with random inputs -> pad_oeb=5'b11111, pad_out=0, alt_own=0, busy=0, all asynchronously. Release, then drive gpio_oe[0]=1, gpio_o[0]=1 -> one edge later pad_oeb[0]=0, pad_out[0]=1.
2. Handover, DEAD_CYC=4: alt_en[2] rises before edge k, alt_oe[2]=1, alt_o[2]=1 -> busy[2]=1 and pad_oeb[2]=1 after edges k..k+3. After edge k+4: alt_own[2]=1, pad_oeb[2]=0, pad_out[2]=1.
3. Release: alt_en[2] falls while in S_ALT -> exactly 4 tri-state cycles, then S_GPIO with pad_out[2]=gpio_o[2] and alt_own[2]=0.
4. Glitch during dead time: pulse alt_en[1] high for 1 cycle from S_GPIO -> 4 dead cycles, then back to S_GPIO. Pulse it again mid-dead -> no extension of the dead time.
5. Lock: mux_lock=1 in S_GPIO, then raise alt_en[3] -> state stays S_GPIO for 20 cycles. Drop mux_lock -> S_DEAD on the next edge. Assert mux_lock inside S_DEAD -> the dead time still completes into S_ALT.
6. Parallel and reset mid-op: raise alt_en on all 5 pads on one edge -> all enter S_ALT on the same edge. Assert rst_ni=0 in the 2nd dead cycle -> immediate tri-state, and S_GPIO after release.
